// File: rtl/coreaxitoahbl_wstrb_split_ctrl_if.sv
// Beat-in / transfer-out handshake bundle for the WSTRB splitter.
// The splitter uses the master modport; the W buffer and AHB master FSM use the slave side.
interface coreaxitoahbl_wstrb_split_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  BEAT_VALID;
    logic                  BEAT_READY;
    logic [ADDR_WIDTH-1:0] BEAT_ADDR;
    logic [7:0]            BEAT_WSTRB;
    logic                  BEAT_LAST;
    logic                  XFER_VALID;
    logic                  XFER_READY;
    logic [ADDR_WIDTH-1:0] XFER_ADDR;
    logic [1:0]            XFER_SIZE;
    logic [7:0]            XFER_LANES;
    logic                  XFER_LAST;
    logic [11:0]           BYTE_CNT;
    logic                  BURST_DONE;
    logic                  STRB_ERR;

    modport master (
        input  BEAT_VALID, BEAT_ADDR, BEAT_WSTRB, BEAT_LAST, XFER_READY,
        output BEAT_READY, XFER_VALID, XFER_ADDR, XFER_SIZE, XFER_LANES,
               XFER_LAST, BYTE_CNT, BURST_DONE, STRB_ERR
    );

    modport slave (
        output BEAT_VALID, BEAT_ADDR, BEAT_WSTRB, BEAT_LAST, XFER_READY,
        input  BEAT_READY, XFER_VALID, XFER_ADDR, XFER_SIZE, XFER_LANES,
               XFER_LAST, BYTE_CNT, BURST_DONE, STRB_ERR
    );
endinterface

// File: rtl/coreaxitoahbl_wstrb_split_ctrl.sv
// Splits one strobed 64-bit AXI write beat into naturally aligned AHB-Lite
// transfers, tracks the burst byte count and flags non-contiguous strobes.
module coreaxitoahbl_wstrb_split_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic ACLK,
    input  logic ARESET,
    coreaxitoahbl_wstrb_split_ctrl_if.master bus
);
    localparam int unsigned HI_WIDTH  = ADDR_WIDTH - 3;
    localparam int unsigned CNT_WIDTH = 12;

    typedef enum logic {IDLE, SPLIT} state_t;

    function automatic logic [2:0] lowestSet(input logic [7:0] strb);
        logic [2:0] off;
        logic       found;
        off   = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && strb[i]) begin
                off   = 3'(i);
                found = 1'b1;
            end
        end
        return off;
    endfunction

    // Zero means empty or non-contiguous strobe.
    function automatic logic [3:0] runLength(input logic [7:0] strb, input logic [2:0] off);
        logic [7:0] shifted;
        logic [3:0] cnt;
        shifted = strb >> off;
        cnt     = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + 4'(shifted[i]);
        end
        if (strb == 8'd0 || (shifted & (shifted + 8'd1)) != 8'd0) begin
            cnt = 4'd0;
        end
        return cnt;
    endfunction

    // Largest naturally aligned piece that fits in the remaining run.
    function automatic logic [1:0] pieceSize(input logic [2:0] off, input logic [3:0] rem);
        if (off == 3'd0 && rem >= 4'd8) begin
            return 2'd3;
        end else if (off[1:0] == 2'd0 && rem >= 4'd4) begin
            return 2'd2;
        end else if (off[0] == 1'b0 && rem >= 4'd2) begin
            return 2'd1;
        end
        return 2'd0;
    endfunction

    function automatic logic [3:0] sizeBytes(input logic [1:0] sz);
        return 4'(4'd1 << sz);
    endfunction

    function automatic logic [7:0] laneMask(input logic [1:0] sz, input logic [2:0] off);
        logic [7:0] base;
        case (sz)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return 8'(base << off);
    endfunction

    state_t                  stateQ;
    logic [HI_WIDTH-1:0]     addrHiQ;
    logic                    lastQ;
    logic [2:0]              offQ;
    logic [3:0]              remQ;
    logic [CNT_WIDTH-1:0]    byteCntQ;
    logic                    cntClrQ;
    logic                    readyQ;
    logic                    xferValidQ;
    logic [ADDR_WIDTH-1:0]   xferAddrQ;
    logic [1:0]              xferSizeQ;
    logic [7:0]              xferLanesQ;
    logic                    xferLastQ;
    logic                    burstDoneQ;
    logic                    strbErrQ;

    logic                    accept;
    logic [2:0]              beatOff;
    logic [3:0]              beatLen;
    logic [1:0]              accSize;
    logic [1:0]              curSize;
    logic [3:0]              curBytes;
    logic [2:0]              nxtOff;
    logic [3:0]              nxtRem;
    logic [1:0]              nxtSize;
    logic                    unusedAddrBits;

    assign accept         = bus.BEAT_VALID && bus.BEAT_READY;
    assign beatOff        = lowestSet(bus.BEAT_WSTRB);
    assign beatLen        = runLength(bus.BEAT_WSTRB, beatOff);
    assign accSize        = pieceSize(beatOff, beatLen);
    assign curSize        = pieceSize(offQ, remQ);
    assign curBytes       = sizeBytes(curSize);
    assign nxtOff         = offQ + curBytes[2:0];
    assign nxtRem         = remQ - curBytes;
    assign nxtSize        = pieceSize(nxtOff, nxtRem);
    assign unusedAddrBits = ^bus.BEAT_ADDR[2:0];

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            stateQ     <= IDLE;
            addrHiQ    <= '0;
            lastQ      <= 1'b0;
            offQ       <= 3'd0;
            remQ       <= 4'd0;
            byteCntQ   <= '0;
            cntClrQ    <= 1'b1;
            readyQ     <= 1'b1;
            xferValidQ <= 1'b0;
            xferAddrQ  <= '0;
            xferSizeQ  <= 2'd0;
            xferLanesQ <= 8'd0;
            xferLastQ  <= 1'b0;
            burstDoneQ <= 1'b0;
            strbErrQ   <= 1'b0;
        end else begin
            burstDoneQ <= 1'b0;
            strbErrQ   <= 1'b0;
            case (stateQ)
                IDLE: begin
                    if (accept) begin
                        if (cntClrQ) begin
                            byteCntQ <= '0;
                            cntClrQ  <= 1'b0;
                        end
                        addrHiQ <= bus.BEAT_ADDR[ADDR_WIDTH-1:3];
                        lastQ   <= bus.BEAT_LAST;
                        if (beatLen == 4'd0) begin
                            strbErrQ <= |bus.BEAT_WSTRB;
                            if (bus.BEAT_LAST) begin
                                burstDoneQ <= 1'b1;
                                cntClrQ    <= 1'b1;
                            end
                        end else begin
                            stateQ     <= SPLIT;
                            readyQ     <= 1'b0;
                            offQ       <= beatOff;
                            remQ       <= beatLen;
                            xferValidQ <= 1'b1;
                            xferAddrQ  <= {bus.BEAT_ADDR[ADDR_WIDTH-1:3], beatOff};
                            xferSizeQ  <= accSize;
                            xferLanesQ <= laneMask(accSize, beatOff);
                            xferLastQ  <= bus.BEAT_LAST && (beatLen == sizeBytes(accSize));
                        end
                    end
                end
                SPLIT: begin
                    if (xferValidQ && bus.XFER_READY) begin
                        byteCntQ <= byteCntQ + CNT_WIDTH'(curBytes);
                        if (nxtRem == 4'd0) begin
                            stateQ     <= IDLE;
                            readyQ     <= 1'b1;
                            xferValidQ <= 1'b0;
                            burstDoneQ <= lastQ;
                            if (lastQ) begin
                                cntClrQ <= 1'b1;
                            end
                        end else begin
                            offQ       <= nxtOff;
                            remQ       <= nxtRem;
                            xferAddrQ  <= {addrHiQ, nxtOff};
                            xferSizeQ  <= nxtSize;
                            xferLanesQ <= laneMask(nxtSize, nxtOff);
                            xferLastQ  <= lastQ && (nxtRem == sizeBytes(nxtSize));
                        end
                    end
                end
                default: stateQ <= IDLE;
            endcase
        end
    end

    // Ready is held low while reset is applied, independent of the registered idle flag.
    assign bus.BEAT_READY = readyQ && !ARESET;
    assign bus.XFER_VALID = xferValidQ;
    assign bus.XFER_ADDR  = xferAddrQ;
    assign bus.XFER_SIZE  = xferSizeQ;
    assign bus.XFER_LANES = xferLanesQ;
    assign bus.XFER_LAST  = xferLastQ;
    assign bus.BYTE_CNT   = byteCntQ;
    assign bus.BURST_DONE = burstDoneQ;
    assign bus.STRB_ERR   = strbErrQ;
endmodule
